alu_multicycle: RTL

Parametrised successor to the single-cycle processor ALU. Adds a valid/ready handshake on both sides, a configurable data width, carry/overflow/illegal flags, an arithmetic right shift, and an iterative shift-add multiplier that takes WIDTH cycles. It sits in the execute stage. The control unit issues operations; the write-back stage drains results.

---
 rtl/alu_multicycle_pkg.sv | 27 ++
 rtl/alu_shift_add_mul.sv | 58 +++++
 rtl/alu_multicycle.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared opcode, state and legality definitions for the multi-cycle ALU.
package alu_multicycle_pkg;

  localparam logic [3:0] ALU_Add = 4'd0;
  localparam logic [3:0] ALU_Sub = 4'd1;
  localparam logic [3:0] ALU_And = 4'd2;
  localparam logic [3:0] ALU_Or  = 4'd3;
  localparam logic [3:0] ALU_Xor = 4'd4;
  localparam logic [3:0] ALU_Sll = 4'd5;
  localparam logic [3:0] ALU_Srl = 4'd6;
  localparam logic [3:0] ALU_Sra = 4'd7;
  localparam logic [3:0] ALU_Mul = 4'd8;

  // Every code from here up to 4'hF is undefined.
  localparam logic [3:0] ALU_ILL_LO = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } alu_state_e;

  function automatic logic op_is_illegal(input logic [3:0] op, input logic mul_en);
    return (op >= ALU_ILL_LO) || ((op == ALU_Mul) && !mul_en);
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
      end else if (busy_q && (cnt_q == CW'(1))) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  // Datapath carries no reset; busy_q gates every update.
  always_ff @(posedge clock) begin
    if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready on both sides; MUL runs on the iterative multiplier.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_ENABLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sig_alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Output,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             flag_illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e         state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_q;
  logic               zero_q, neg_q, carry_q, ovf_q, ill_q;

  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]          sum, diff;
  logic signed [WIDTH-1:0] a_sgn;
  logic [SHW-1:0]          shamt;
  logic                    shift_big;
  logic [WIDTH-1:0]        res_d;
  logic                    carry_d, ovf_d, ill_d;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (sig_alu_op == ALU_Mul) && (MUL_ENABLE != 0);
  assign mul_start = accept && is_mul;

  assign sum       = {1'b0, A} + {1'b0, B};
  assign diff      = {1'b0, A} - {1'b0, B};
  assign a_sgn     = A;
  assign shamt     = B[SHW-1:0];
  assign shift_big = |B[WIDTH-1:SHW];

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    if (op_is_illegal(sig_alu_op, MUL_ENABLE != 0)) begin
      ill_d = 1'b1;
    end else begin
      case (sig_alu_op)
        ALU_Add: begin
          res_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
          ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        end
        ALU_Sub: begin
          res_d   = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
          ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        end
        ALU_And: res_d = A & B;
        ALU_Or:  res_d = A | B;
        ALU_Xor: res_d = A ^ B;
        ALU_Sll: res_d = shift_big ? '0 : (A << shamt);
        ALU_Srl: res_d = shift_big ? '0 : (A >> shamt);
        ALU_Sra: res_d = shift_big ? {WIDTH{A[WIDTH-1]}} : WIDTH'(a_sgn >>> shamt);
        default: res_d = '0;
      endcase
    end
  end

  generate
    if (MUL_ENABLE != 0) begin : g_mul
      alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start_i (mul_start),
        .a_i     (A),
        .b_i     (B),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_MUL_BUSY;
            end else begin
              out_q       <= res_d;
              zero_q      <= (res_d == '0);
              neg_q       <= res_d[WIDTH-1];
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              ill_q       <= ill_d;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_MUL_BUSY: begin
          // Product is complete the cycle after the multiplier's last step.
          if (mul_done) begin
            out_q       <= mul_prod[WIDTH-1:0];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            neg_q       <= mul_prod[WIDTH-1];
            carry_q     <= 1'b0;
            ovf_q       <= |mul_prod[2*WIDTH-1:WIDTH];
            ill_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign Output        = out_q;
  assign flag_zero     = zero_q;
  assign flag_negative = neg_q;
  assign flag_carry    = carry_q;
  assign flag_overflow = ovf_q;
  assign flag_illegal  = ill_q;

endmodule
